fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the datapath and supplies its `Instr`/`PC` inputs. It owns the fetch PC and issues word reads to instruction memory over a request/grant/response handshake. Returned words are buffered in a small instruction queue and presented to decode with valid/ready. A taken branch or jump, signalled as `PCSrc`/`PCTarget` from the datapath, flushes the queue and discards any in-flight response.

---
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one-at-a-time word reads and buffers returns in a small queue.
// Optional macro FETCH_MISALIGN_CHECK_EN flags and blocks fetch on redirects to non-word-aligned targets.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        valid,
    input  logic        ready,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic        misaligned
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Handshakes: a request is accepted when imem_req && imem_gnt on the same edge;
    // decode takes the head when valid && ready; a redirect (PCSrc) overrides both.
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_fpc;
    logic [31:0]   r_infl_addr;
    logic [31:0]   r_q_instr [QDEPTH];
    logic [31:0]   r_q_pc    [QDEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_empty;
    logic          w_has_room;
    logic          w_grant;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_target;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misaligned;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_misaligned <= 1'b0;
        end else if (PCSrc) begin
            r_misaligned <= |PCTarget[1:0];
        end
    end

    assign w_target   = PCTarget;
    assign misaligned = r_misaligned;
`else
    assign w_target   = PCTarget & 32'hFFFF_FFFC;
    assign misaligned = 1'b0;
`endif

    assign w_empty    = (r_count == '0);
    assign w_has_room = (r_count < CW'(QDEPTH));
    // A grant only counts when a request was eligible; it is honoured even if a redirect lands on it.
    assign w_grant    = (r_state == S_REQ) && imem_gnt && w_has_room && !misaligned;
    assign w_push     = (r_state == S_WAIT) && imem_rvalid && !PCSrc;
    assign w_pop      = valid && ready;

    assign imem_req  = !reset && (r_state == S_REQ) && w_has_room && !misaligned && !PCSrc;
    assign imem_addr = r_fpc;
    assign valid     = !w_empty && !PCSrc;
    assign Instr     = w_empty ? NOP : r_q_instr[r_rd_ptr];
    assign PC        = w_empty ? 32'h0 : r_q_pc[r_rd_ptr];
    assign PCPlus4   = PC + 32'd4;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_REQ:   if (w_grant) w_next = PCSrc ? S_DROP : S_WAIT;
            S_WAIT: begin
                if (imem_rvalid)  w_next = S_REQ;
                else if (PCSrc)   w_next = S_DROP;
            end
            S_DROP:  if (imem_rvalid) w_next = S_REQ;
            default: w_next = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_REQ;
            r_fpc       <= RESET_PC;
            r_infl_addr <= RESET_PC;
        end else begin
            r_state <= w_next;
            if (w_grant) r_infl_addr <= r_fpc;
            if (PCSrc)        r_fpc <= w_target;
            else if (w_grant) r_fpc <= r_fpc + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (PCSrc) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage needs no reset: entries are only read while count covers them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= imem_rdata;
            r_q_pc[r_wr_ptr]    <= r_infl_addr;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table for streaming/backpressure, hand sequences for redirect and reset corners.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        valid;
    logic        ready;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        misaligned;

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4), .valid(valid), .ready(ready),
        .PCSrc(PCSrc), .PCTarget(PCTarget), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] req_q[$];

    int          lat;
    bit          gnt_en;
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    typedef struct {
        bit          rdy;
        bit          req;
        logic [31:0] addr;
        bit          vld;
        logic [31:0] pc;
    } vec_t;
    vec_t vecs[16];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model plus scoreboard for one cycle; called at the falling edge after inputs are set.
    task automatic settle();
        logic [31:0] e;
        #1;
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_data(mem_addr);
                mem_busy    = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        if (gnt_en && imem_req === 1'b1 && !mem_busy && req_q.size() > 0) begin
            imem_gnt = 1'b1;
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_cnt  = lat - 1;
            chk("req_addr", imem_addr, req_q.pop_front());
        end
        #1;
        if (valid === 1'b1 && ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got pc %h expected none", PC);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", PC, e);
                chk("pop_instr", Instr, mem_data(e));
                chk("pop_pc4", PCPlus4, e + 32'd4);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        ready    = 1'b0;
        PCSrc    = 1'b0;
        PCTarget = 32'h0;
        mem_busy = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        exp_q.delete();
        req_q.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        ready  = 1'b1;
        PCSrc  = 1'b0;
        gnt_en = 1'b1;
        while (exp_q.size() > 0 && n < budget) begin
            settle();
            tick();
            n++;
        end
        chk({name, "_exp_left"}, exp_q.size(), 0);
        chk({name, "_req_left"}, req_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
        vecs[2]  = '{1'b1, 1'b1, 32'h04, 1'b1, 32'h00};
        vecs[3]  = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
        vecs[4]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
        vecs[5]  = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
        vecs[6]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h08};
        vecs[7]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
        vecs[8]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h0C};
        vecs[9]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
        vecs[10] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
        vecs[11] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
        vecs[12] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
        vecs[13] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h10};
        vecs[14] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
        vecs[15] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h14};

        imem_rdata = 32'h0;
        lat    = 1;
        gnt_en = 1'b1;
        @(negedge clk);
        do_reset();
        reset = 1'b1;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", valid, 0);
        chk("rst_instr", Instr, 32'h0000_0013);
        chk("rst_pc", PC, 32'h0);
        chk("rst_pc4", PCPlus4, 32'h4);
        chk("rst_misaligned", misaligned, 0);
        @(negedge clk);
        reset = 1'b0;

        // Streaming with single-cycle memory, then backpressure filling the 2-deep queue.
        lat = 1;
        foreach (vecs[i]) if (vecs[i].req) req_q.push_back(vecs[i].addr);
        exp_q = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};
        for (int i = 0; i < 16; i++) begin
            ready = vecs[i].rdy;
            PCSrc = 1'b0;
            settle();
            chk($sformatf("t%0d_req", i), imem_req, vecs[i].req);
            if (vecs[i].req) chk($sformatf("t%0d_addr", i), imem_addr, vecs[i].addr);
            chk($sformatf("t%0d_valid", i), valid, vecs[i].vld);
            if (vecs[i].vld) chk($sformatf("t%0d_pc", i), PC, vecs[i].pc);
            tick();
        end
        chk("tbl_exp_left", exp_q.size(), 0);
        chk("tbl_req_left", req_q.size(), 0);

        // Redirect to 0x100 while waiting on 0x4; the queued 0x0 is flushed too.
        do_reset();
        lat = 2;
        req_q = '{32'h0, 32'h4, 32'h100};
        exp_q = '{32'h100};
        ready = 1'b0;
        repeat (4) begin settle(); tick(); end
        PCSrc = 1'b1;
        PCTarget = 32'h100;
        settle();
        chk("rdw_valid", valid, 0);
        chk("rdw_req", imem_req, 0);
        tick();
        PCSrc = 1'b0;
        ready = 1'b1;
        settle();
        chk("drop_rvalid_seen", imem_rvalid, 1);
        chk("drop_valid", valid, 0);
        chk("drop_req", imem_req, 0);
        tick();
        settle();
        chk("rdw_next_req", imem_req, 1);
        chk("rdw_next_addr", imem_addr, 32'h100);
        tick();
        drain("rdw", 40);

        // Redirect to 0x200 in the same cycle as the response.
        do_reset();
        lat = 1;
        req_q = '{32'h0, 32'h200};
        exp_q = '{32'h200};
        ready = 1'b1;
        settle();
        tick();
        PCSrc = 1'b1;
        PCTarget = 32'h200;
        settle();
        chk("rdr_rvalid_seen", imem_rvalid, 1);
        chk("rdr_req", imem_req, 0);
        tick();
        PCSrc = 1'b0;
        settle();
        chk("rdr_valid", valid, 0);
        chk("rdr_next_req", imem_req, 1);
        chk("rdr_next_addr", imem_addr, 32'h200);
        tick();
        drain("rdr", 40);

        // Address wrap through the top of the 32-bit space.
        do_reset();
        lat = 1;
        req_q = '{32'hFFFF_FFFC, 32'h0};
        exp_q = '{32'hFFFF_FFFC, 32'h0};
        ready = 1'b1;
        PCSrc = 1'b1;
        PCTarget = 32'hFFFF_FFFC;
        settle();
        tick();
        drain("wrap", 40);

        // Misaligned redirect target.
        do_reset();
        lat = 1;
        ready = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
        req_q = '{32'h300};
        exp_q = '{32'h300};
        PCSrc = 1'b1;
        PCTarget = 32'h102;
        settle();
        tick();
        PCSrc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("mis_flag", misaligned, 1);
            chk("mis_req", imem_req, 0);
            tick();
        end
        PCSrc = 1'b1;
        PCTarget = 32'h300;
        settle();
        chk("mis_redir_req", imem_req, 0);
        tick();
        PCSrc = 1'b0;
        settle();
        chk("mis_clear", misaligned, 0);
        chk("mis_req_300", imem_req, 1);
        chk("mis_addr_300", imem_addr, 32'h300);
        tick();
        drain("mis", 40);
`else
        req_q = '{32'h100};
        exp_q = '{32'h100};
        PCSrc = 1'b1;
        PCTarget = 32'h102;
        settle();
        tick();
        PCSrc = 1'b0;
        settle();
        chk("mask_flag", misaligned, 0);
        chk("mask_req", imem_req, 1);
        chk("mask_addr", imem_addr, 32'h100);
        tick();
        drain("mask", 40);
`endif

        // Reset while waiting; the late response after release must be ignored.
        do_reset();
        chk("rw_misaligned", misaligned, 0);
        lat = 3;
        req_q = '{32'h0, 32'h0};
        exp_q = '{32'h0};
        ready = 1'b1;
        settle();
        tick();
        settle();
        tick();
        reset = 1'b1;
        settle();
        chk("rw_req_in_reset", imem_req, 0);
        chk("rw_valid_in_reset", valid, 0);
        tick();
        reset  = 1'b0;
        gnt_en = 1'b0;
        settle();
        chk("rw_stale_rvalid", imem_rvalid, 1);
        chk("rw_req", imem_req, 1);
        chk("rw_addr", imem_addr, 32'h0);
        chk("rw_valid0", valid, 0);
        tick();
        settle();
        chk("rw_valid1", valid, 0);
        tick();
        drain("rw", 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
